// File: rtl/apb4_slave_if.sv
// apb4_slave_if
// APB4 slave front-end for register-file based peripherals. Turns the APB
// setup/access handshake into single-cycle register write/read strobes and
// holds the captured address, write data and byte strobes for the register
// file. Supports fixed wait states, register-side back-pressure and PSLVERR
// for out-of-range, misaligned, privilege-violating or flagged accesses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   psel, penable     APB handshake
//   pwrite, paddr     direction and byte address
//   pwdata, pstrb     write data and write byte lanes
//   pprot             protection (bit 0 = privileged)
//   prdata, pready,   read data, transfer complete, transfer error
//   pslverr
//   wr_en, rd_en      one-cycle register strobes, coincident with pready
//   reg_addr,         captured address / write data / byte strobes
//   reg_wdata,
//   reg_wstrb
//   reg_rdata         register read data (combinational on reg_addr)
//   reg_err           register file rejects the addressed location
//   reg_busy          register file not ready; holds completion
module apb4_slave_if #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 32,
  parameter int                WAIT_CYCLES  = 0,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT   = 12'h400,
  parameter bit                PRIV_WR_ONLY = 1'b0,
  localparam int               STRB_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  input  logic [2:0]        pprot,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [STRB_W-1:0] reg_wstrb,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_err,
  input  logic              reg_busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int                CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(STRB_W - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             wr_p0;
  logic             prot0_p0;

  logic             access_ok;
  logic             done;
  logic             err;
  logic             unused_prot;

  // Only the privilege bit of pprot is meaningful here.
  assign unused_prot = ^pprot[2:1];

  // Setup-phase capture and access-phase sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      wr_p0     <= 1'b0;
      prot0_p0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // penable without a preceding setup phase is ignored.
          if (psel && !penable) begin
            state     <= ACCESS;
            cnt       <= CNT_LOAD;
            reg_addr  <= paddr;
            reg_wdata <= pwdata;
            reg_wstrb <= pwrite ? pstrb : '0;
            wr_p0     <= pwrite;
            prot0_p0  <= pprot[0];
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!reg_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access-phase completion
  // Counter expiry with reg_busy high keeps the transfer waiting.
  assign access_ok = (state == ACCESS) && psel && penable;
  assign done      = access_ok && (cnt == '0) && !reg_busy;

  assign err = (reg_addr >= ADDR_LIMIT)
             | (|(reg_addr & LANE_MASK))
             | reg_err
             | (PRIV_WR_ONLY && wr_p0 && !prot0_p0);

  assign pready  = done;
  assign pslverr = done && err;
  assign wr_en   = done && wr_p0 && !err;
  assign rd_en   = done && !wr_p0 && !err;
  assign prdata  = (done && !wr_p0 && !err) ? reg_rdata : '0;

endmodule

// File: doc/apb4_slave_if.md
# apb4_slave_if

Parameterised APB4 slave front-end for the timer IP and sibling peripherals; the successor of the fixed 12-bit/32-bit timer APB slave. It decodes the APB handshake into single-cycle register-file write/read strobes and captures address, write data and byte strobes. It adds programmable wait states, a register-side back-pressure input, write byte strobes, and PSLVERR generation for out-of-range, misaligned, privilege-violating or register-flagged accesses. It sits between the APB interconnect and the peripheral register file.

## Interface
Parameters:
- ADDR_W, 12, paddr / reg_addr width
- DATA_W, 32, data width; must be 8, 16 or 32; STRB_W = DATA_W/8
- WAIT_CYCLES, 0, fixed wait states inserted in every access phase (0..15)
- ADDR_LIMIT, 12'h400, first invalid byte address; paddr >= ADDR_LIMIT -> error
- PRIV_WR_ONLY, 0, 1 = writes with pprot[0]=0 (unprivileged) are rejected

Ports (one clock `clk`; reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  STRB_W  write byte lanes
- pprot  in  3  protection; only bit 0 used
- prdata  out  DATA_W  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid only with pready
- wr_en  out  1  one-cycle register write strobe
- rd_en  out  1  one-cycle register read strobe
- reg_addr  out  ADDR_W  captured address
- reg_wdata  out  DATA_W  captured write data
- reg_wstrb  out  STRB_W  captured strobes (forced 0 on reads)
- reg_rdata  in  DATA_W  register-file read data, combinational on reg_addr
- reg_err  in  1  register file flags the addressed location as invalid/read-only
- reg_busy  in  1  register file not ready; holds completion

## Operation
- States: IDLE, ACCESS.
- IDLE: pready=0. If psel=1 and penable=0 (setup phase): capture paddr, pwdata, pstrb (0 if read), pwrite, pprot[0] into regs; load wait counter with WAIT_CYCLES; go ACCESS. penable=1 without a preceding setup is ignored.
- ACCESS: if psel=0 or penable=0 -> abort, go IDLE, no strobe, pready stays 0. Else if counter != 0 -> decrement, pready=0. Else if reg_busy=1 -> hold, pready=0. Else completion cycle: pready=1, go IDLE.
- Error term err = (reg_addr >= ADDR_LIMIT) | (reg_addr[log2(STRB_W)-1:0] != 0) | reg_err | (PRIV_WR_ONLY & write & !prot0).
- Completion, no error: write -> wr_en=1; read -> rd_en=1, prdata=reg_rdata.
- Completion with error: pslverr=1, wr_en=rd_en=0, prdata=0. Write strobe pstrb=0 is not an error (no-op write, wr_en still 1).
- Outside completion: pready=pslverr=wr_en=rd_en=0, prdata=0.
- Back-to-back: completion cycle followed directly by next setup phase is handled from IDLE with no bubble.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1 bit; no wrap (stops at 0).

## Timing
- Reset: state=IDLE, counter=0, reg_addr/reg_wdata/reg_wstrb=0, all outputs 0. rst mid-transfer aborts with no strobe; pready never asserts for that transfer.
- pready, pslverr, wr_en, rd_en, prdata combinational from state, counter, reg_busy, reg_err, reg_rdata; all others registered.
- Latency (setup edge to pready) = 1 + WAIT_CYCLES + busy cycles; WAIT_CYCLES=0, reg_busy=0 gives zero-wait APB (pready in first access cycle).
- wr_en/rd_en: exactly one cycle per completed transfer, coincident with pready.
- reg_busy and counter expiry together: busy wins, pready deferred.

## Test plan
- WAIT_CYCLES=0: write 0x004 data 0xDEADBEEF pstrb 4'hF -> pready and wr_en high in first access cycle, reg_wdata=0xDEADBEEF, pslverr=0.
- WAIT_CYCLES=3: read 0x008, reg_rdata=0x12345678 -> pready low 3 access cycles, 4th cycle pready=rd_en=1, prdata=0x12345678.
- Errors: write 0x400 (ADDR_LIMIT) -> pslverr=1, wr_en=0; read 0x006 -> pslverr=1, prdata=0; PRIV_WR_ONLY=1, pprot=3'b000 write -> pslverr=1.
- reg_busy high 2 cycles during WAIT_CYCLES=0 read -> pready at 3rd access cycle, single rd_en pulse.
- Back-to-back write 0x000 then read 0x000 -> two single-cycle strobes, no idle gap; psel dropped mid-ACCESS -> no strobe, returns IDLE.
- rst asserted during wait cycle 2 of 3 -> no pready/wr_en, all outputs 0 next cycle, next transfer completes normally.
